// File: rtl/hazard_ctrl_dual.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_dual
// Hazard and stall controller for the dual-issue MIPS pipeline. It generates
// every F/D/E/M/W register enable and flush from these sources:
//   - load-use hazards: any valid decode lane reads a register that a load in
//     E or M is about to write
//   - intra-bundle RAW: the slave lane reads the master lane's destination
//     (reported on D_slave_hold only; it never stalls the pipe)
//   - multi-cycle divide: an internal RUN/DIV state machine holds the back end
//   - instruction- and data-cache misses
//   - exceptions in M: deferred while the data cache is stalled
// It also keeps a saturating count of cycles in which fetch was frozen.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   D_valid, D_rs, D_rt       decode lane valid and source registers (packed
//                             per lane, lane i at [i*REG_AW +: REG_AW])
//   D_master_regwrite/waddr   destination of the master decode instruction
//   E_/M_memtoReg, E_/M_waddr load flag and destination per lane in E and M
//   E_branch_taken            branch resolved taken in E
//   E_div_start               divide present in E (level, held while stalled)
//   i_stall, d_stall          cache miss stalls
//   M_except                  exception detected in M
//   X_ena, X_flush            pipeline register enables / synchronous clears.
//                             The pipeline registers give a flush priority
//                             over the enable of the same register.
//   D_slave_hold              slave lane must not issue this cycle
//   div_ready                 one-cycle pulse when the divide result is valid
//   stall_cnt                 saturating count of cycles with F_ena == 0
// -----------------------------------------------------------------------------
module hazard_ctrl_dual #(
   parameter int ISSUE_W    = 2,
   parameter int REG_AW     = 5,
   parameter int DIV_CYCLES = 34,
   parameter int CNT_W      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ISSUE_W-1:0]        D_valid,
   input  logic [ISSUE_W*REG_AW-1:0] D_rs,
   input  logic [ISSUE_W*REG_AW-1:0] D_rt,
   input  logic                      D_master_regwrite,
   input  logic [REG_AW-1:0]         D_master_waddr,
   input  logic [ISSUE_W-1:0]        E_memtoReg,
   input  logic [ISSUE_W*REG_AW-1:0] E_waddr,
   input  logic [ISSUE_W-1:0]        M_memtoReg,
   input  logic [ISSUE_W*REG_AW-1:0] M_waddr,
   input  logic                      E_branch_taken,
   input  logic                      E_div_start,
   input  logic                      i_stall,
   input  logic                      d_stall,
   input  logic                      M_except,
   output logic                      F_ena,
   output logic                      D_ena,
   output logic                      E_ena,
   output logic                      M_ena,
   output logic                      W_ena,
   output logic                      F_flush,
   output logic                      D_flush,
   output logic                      E_flush,
   output logic                      M_flush,
   output logic                      W_flush,
   output logic                      D_slave_hold,
   output logic                      div_ready,
   output logic [CNT_W-1:0]          stall_cnt
);

   localparam int CW = $clog2(DIV_CYCLES + 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES);

   typedef enum logic {RUN = 1'b0, DIV = 1'b1} div_state_t;

   div_state_t        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              except_pend_q;
   logic              lwstall, div_stall, back_stall;
   logic              except_fire, branch_flush, div_ready_c;
   logic [REG_AW-1:0] slave_rs, slave_rt;

   // Load-use: every valid decode lane against every load lane in E and M.
   // Register 0 is hard-wired zero, so a load targeting it never matches.
   always_comb begin
      lwstall = 1'b0;
      for (int i = 0; i < ISSUE_W; i++) begin
         for (int j = 0; j < ISSUE_W; j++) begin
            if (D_valid[i] && E_memtoReg[j] && (E_waddr[j*REG_AW +: REG_AW] != '0) &&
                ((D_rs[i*REG_AW +: REG_AW] == E_waddr[j*REG_AW +: REG_AW]) ||
                 (D_rt[i*REG_AW +: REG_AW] == E_waddr[j*REG_AW +: REG_AW])))
               lwstall = 1'b1;
            if (D_valid[i] && M_memtoReg[j] && (M_waddr[j*REG_AW +: REG_AW] != '0) &&
                ((D_rs[i*REG_AW +: REG_AW] == M_waddr[j*REG_AW +: REG_AW]) ||
                 (D_rt[i*REG_AW +: REG_AW] == M_waddr[j*REG_AW +: REG_AW])))
               lwstall = 1'b1;
         end
      end
   end

   // Slave depends on the master in the same bundle: slave is held back, the
   // master still issues, so nothing else in the pipe is affected.
   assign slave_rs     = D_rs[REG_AW +: REG_AW];
   assign slave_rt     = D_rt[REG_AW +: REG_AW];
   assign D_slave_hold = D_valid[1] & D_master_regwrite & (D_master_waddr != '0) &
                         ((slave_rs == D_master_waddr) | (slave_rt == D_master_waddr));

   // An exception that arrives while the data cache is stalled waits until the
   // stall drops, so the flush is not lost behind frozen registers.
   assign except_fire  = (M_except | except_pend_q) & ~d_stall;

   // Divider FSM. The cycle that enters DIV already stalls (cnt becomes 1), so
   // the back end is held for exactly DIV_CYCLES cycles; the release cycle
   // ignores E_div_start, which is still high for the same divide.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      div_stall   = 1'b0;
      div_ready_c = 1'b0;
      case (state_q)
         RUN: begin
            if (E_div_start) begin
               div_stall = 1'b1;
               state_d   = DIV;
               cnt_d     = CW'(1);
            end
         end
         DIV: begin
            if (cnt_q < DIV_LAST) begin
               div_stall = 1'b1;
               cnt_d     = cnt_q + CW'(1);
            end else begin
               div_ready_c = 1'b1;
               state_d     = RUN;
               cnt_d       = '0;
            end
         end
         default: state_d = RUN;
      endcase
      // An exception kills the divide in flight; its result is never reported.
      if (except_fire) begin
         state_d     = RUN;
         cnt_d       = '0;
         div_ready_c = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         cnt_q         <= '0;
         except_pend_q <= 1'b0;
         stall_cnt     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (except_fire)
            except_pend_q <= 1'b0;
         else if (M_except && d_stall)
            except_pend_q <= 1'b1;
         if (!F_ena && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign back_stall   = d_stall | div_stall;
   assign branch_flush = E_branch_taken & ~back_stall & ~except_fire;

   assign E_ena = ~back_stall;
   assign M_ena = ~back_stall;
   assign W_ena = ~back_stall;
   assign D_ena = ~(back_stall | lwstall);
   assign F_ena = ~(back_stall | lwstall | i_stall);

   // Fetch miss with decode free to advance: push a bubble into D.
   // Load-use with the back end moving: push a bubble into E.
   assign F_flush = 1'b0;
   assign W_flush = 1'b0;
   assign D_flush = except_fire | branch_flush | (i_stall & ~lwstall & ~back_stall);
   assign E_flush = except_fire | branch_flush | (lwstall & ~back_stall);
   assign M_flush = except_fire;

   assign div_ready = div_ready_c;

endmodule

// File: tb/tb_hazard_ctrl_dual.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_dual
// Directed bench for hazard_ctrl_dual. Inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge. A second instance with a
// 3-bit stall counter shares all inputs and covers counter saturation.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_dual;

   localparam int ISSUE_W = 2;
   localparam int REG_AW  = 5;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [ISSUE_W-1:0]        D_valid;
   logic [ISSUE_W*REG_AW-1:0] D_rs, D_rt;
   logic                      D_master_regwrite;
   logic [REG_AW-1:0]         D_master_waddr;
   logic [ISSUE_W-1:0]        E_memtoReg, M_memtoReg;
   logic [ISSUE_W*REG_AW-1:0] E_waddr, M_waddr;
   logic                      E_branch_taken, E_div_start, i_stall, d_stall, M_except;
   logic F_ena, D_ena, E_ena, M_ena, W_ena;
   logic F_flush, D_flush, E_flush, M_flush, W_flush;
   logic D_slave_hold, div_ready;
   logic [31:0] stall_cnt;

   logic s_F_ena, s_D_ena, s_E_ena, s_M_ena, s_W_ena;
   logic s_F_flush, s_D_flush, s_E_flush, s_M_flush, s_W_flush;
   logic s_hold, s_ready;
   logic [2:0] s_stall_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hazard_ctrl_dual #(.ISSUE_W(2), .REG_AW(5), .DIV_CYCLES(34), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt),
      .D_master_regwrite(D_master_regwrite), .D_master_waddr(D_master_waddr),
      .E_memtoReg(E_memtoReg), .E_waddr(E_waddr), .M_memtoReg(M_memtoReg), .M_waddr(M_waddr),
      .E_branch_taken(E_branch_taken), .E_div_start(E_div_start), .i_stall(i_stall),
      .d_stall(d_stall), .M_except(M_except),
      .F_ena(F_ena), .D_ena(D_ena), .E_ena(E_ena), .M_ena(M_ena), .W_ena(W_ena),
      .F_flush(F_flush), .D_flush(D_flush), .E_flush(E_flush), .M_flush(M_flush),
      .W_flush(W_flush), .D_slave_hold(D_slave_hold), .div_ready(div_ready),
      .stall_cnt(stall_cnt)
   );

   hazard_ctrl_dual #(.ISSUE_W(2), .REG_AW(5), .DIV_CYCLES(34), .CNT_W(3)) u_sat (
      .clk(clk), .rst(rst), .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt),
      .D_master_regwrite(D_master_regwrite), .D_master_waddr(D_master_waddr),
      .E_memtoReg(E_memtoReg), .E_waddr(E_waddr), .M_memtoReg(M_memtoReg), .M_waddr(M_waddr),
      .E_branch_taken(E_branch_taken), .E_div_start(E_div_start), .i_stall(i_stall),
      .d_stall(d_stall), .M_except(M_except),
      .F_ena(s_F_ena), .D_ena(s_D_ena), .E_ena(s_E_ena), .M_ena(s_M_ena), .W_ena(s_W_ena),
      .F_flush(s_F_flush), .D_flush(s_D_flush), .E_flush(s_E_flush), .M_flush(s_M_flush),
      .W_flush(s_W_flush), .D_slave_hold(s_hold), .div_ready(s_ready),
      .stall_cnt(s_stall_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      D_valid = '0; D_rs = '0; D_rt = '0;
      D_master_regwrite = 1'b0; D_master_waddr = '0;
      E_memtoReg = '0; E_waddr = '0; M_memtoReg = '0; M_waddr = '0;
      E_branch_taken = 1'b0; E_div_start = 1'b0;
      i_stall = 1'b0; d_stall = 1'b0; M_except = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      int ready_at;
      int n_st;
      int n_pulse;

      // ---------------- reset state ----------------
      rst = 1'b1;
      clear_inputs();
      cyc();
      cyc();
      @(negedge clk);
      check_eq("rst_stall_cnt", stall_cnt, 0);
      check_eq("rst_div_ready", {31'd0, div_ready}, 0);
      check_eq("rst_enables", {27'd0, F_ena, D_ena, E_ena, M_ena, W_ena}, 5'b11111);
      check_eq("rst_flushes", {27'd0, F_flush, D_flush, E_flush, M_flush, W_flush}, 0);
      cyc();
      rst = 1'b0;

      // ---------------- load-use ----------------
      // E lane1 load to r7, D lane0 reads rs=r7
      E_memtoReg = 2'b10; E_waddr = {5'd7, 5'd0};
      D_valid = 2'b01; D_rs = {5'd0, 5'd7};
      @(negedge clk);
      check_eq("lw_e_F_ena", {31'd0, F_ena}, 0);
      check_eq("lw_e_D_ena", {31'd0, D_ena}, 0);
      check_eq("lw_e_E_flush", {31'd0, E_flush}, 1);
      check_eq("lw_e_D_flush", {31'd0, D_flush}, 0);
      cyc();
      // Load to r0 with rs=r0: no hazard
      E_memtoReg = 2'b01; E_waddr = {5'd0, 5'd0}; D_rs = '0;
      @(negedge clk);
      check_eq("lw_r0_F_ena", {31'd0, F_ena}, 1);
      check_eq("lw_r0_E_flush", {31'd0, E_flush}, 0);
      cyc();
      // M lane0 load to r3, D lane1 reads rt=r3
      E_memtoReg = '0; M_memtoReg = 2'b01; M_waddr = {5'd0, 5'd3};
      D_valid = 2'b10; D_rt = {5'd3, 5'd0};
      @(negedge clk);
      check_eq("lw_m_D_ena", {31'd0, D_ena}, 0);
      check_eq("lw_m_E_flush", {31'd0, E_flush}, 1);
      cyc();
      // Same match but the lane is not valid
      D_valid = 2'b01;
      @(negedge clk);
      check_eq("lw_invalid_F_ena", {31'd0, F_ena}, 1);
      check_eq("lw_stall_cnt", stall_cnt, 2);
      cyc();
      clear_inputs();

      // ---------------- intra-bundle RAW ----------------
      D_valid = 2'b11; D_master_regwrite = 1'b1; D_master_waddr = 5'd9;
      D_rt = {5'd9, 5'd0};
      @(negedge clk);
      check_eq("raw_hold", {31'd0, D_slave_hold}, 1);
      check_eq("raw_enables", {27'd0, F_ena, D_ena, E_ena, M_ena, W_ena}, 5'b11111);
      cyc();
      D_valid = 2'b01;
      @(negedge clk);
      check_eq("raw_slave_invalid", {31'd0, D_slave_hold}, 0);
      cyc();
      D_valid = 2'b11; D_master_waddr = 5'd0; D_rt = '0;
      @(negedge clk);
      check_eq("raw_r0", {31'd0, D_slave_hold}, 0);
      cyc();
      D_master_waddr = 5'd12; D_master_regwrite = 1'b0; D_rs = {5'd12, 5'd0};
      @(negedge clk);
      check_eq("raw_no_regwrite", {31'd0, D_slave_hold}, 0);
      cyc();

      // ---------------- divide latency ----------------
      do_reset();
      E_div_start = 1'b1;
      ready_at = -1;
      n_st = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (div_ready) begin
            ready_at = k;
            break;
         end
         if (!E_ena) n_st++;
         cyc();
      end
      check_eq("div_ready_cycle", ready_at, 34);
      check_eq("div_stall_cycles", n_st, 34);
      check_eq("div_release_E_ena", {31'd0, E_ena}, 1);
      check_eq("div_stall_cnt", stall_cnt, 34);
      cyc();
      E_div_start = 1'b0;
      @(negedge clk);
      check_eq("div_ready_pulse_end", {31'd0, div_ready}, 0);
      check_eq("div_after_E_ena", {31'd0, E_ena}, 1);
      cyc();

      // ---------------- deferred exception ----------------
      d_stall = 1'b1; M_except = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_eq("exc_defer_M_flush", {31'd0, M_flush}, 0);
         check_eq("exc_defer_E_ena", {31'd0, E_ena}, 0);
         cyc();
      end
      d_stall = 1'b0; M_except = 1'b0;
      @(negedge clk);
      check_eq("exc_fire_flushes", {29'd0, D_flush, E_flush, M_flush}, 3'b111);
      cyc();
      @(negedge clk);
      check_eq("exc_pend_cleared", {31'd0, M_flush}, 0);
      cyc();

      // ---------------- exception during divide ----------------
      E_div_start = 1'b1;
      for (int k = 0; k < 9; k++) cyc();
      M_except = 1'b1;
      @(negedge clk);
      check_eq("exc_div_flushes", {29'd0, D_flush, E_flush, M_flush}, 3'b111);
      cyc();
      M_except = 1'b0; E_div_start = 1'b0;
      @(negedge clk);
      check_eq("exc_div_E_ena", {31'd0, E_ena}, 1);
      n_pulse = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (div_ready) n_pulse++;
         cyc();
      end
      check_eq("exc_div_no_ready", n_pulse, 0);

      // ---------------- i-cache miss and branch ----------------
      i_stall = 1'b1;
      @(negedge clk);
      check_eq("istall_F_ena", {31'd0, F_ena}, 0);
      check_eq("istall_D_flush", {31'd0, D_flush}, 1);
      check_eq("istall_E_flush", {31'd0, E_flush}, 0);
      cyc();
      i_stall = 1'b0; E_branch_taken = 1'b1; d_stall = 1'b1;
      @(negedge clk);
      check_eq("br_dstall_flush", {30'd0, D_flush, E_flush}, 0);
      check_eq("br_dstall_E_ena", {31'd0, E_ena}, 0);
      cyc();
      d_stall = 1'b0;
      @(negedge clk);
      check_eq("br_flush", {30'd0, D_flush, E_flush}, 2'b11);
      check_eq("br_M_flush", {31'd0, M_flush}, 0);
      cyc();
      clear_inputs();

      // ---------------- counter saturation ----------------
      do_reset();
      i_stall = 1'b1;
      for (int k = 0; k < 10; k++) cyc();
      i_stall = 1'b0;
      @(negedge clk);
      check_eq("cnt_wide", stall_cnt, 10);
      check_eq("cnt_saturated", {29'd0, s_stall_cnt}, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_dual.md
Name: hazard_ctrl_dual

Overview:
Next-generation pipeline hazard and stall controller for the dual-issue MIPS core. It is parametrised in issue width and register-address width, and checks load-use hazards for every decode lane against every E/M load lane. It adds four things:
- intra-bundle RAW detection for the slave lane;
- an internal divider-latency state machine;
- instruction- and data-cache stall handling;
- a deferred exception flush and a saturating stall-cycle performance counter.

It sits beside the F/D/E/M/W pipeline registers and drives all their enables and flushes.

Parameters:
ISSUE_W, 2, number of issue lanes (lane 0 = master, lane 1 = slave)
REG_AW, 5, register address width
DIV_CYCLES, 34, cycles the back end is held per divide (must be >= 2)
CNT_W, 32, stall performance counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
D_valid  in  ISSUE_W  decode lane valid
D_rs  in  ISSUE_W*REG_AW  decode rs per lane (lane i at [i*REG_AW +: REG_AW])
D_rt  in  ISSUE_W*REG_AW  decode rt per lane
D_master_regwrite  in  1  master decode instruction writes a register
D_master_waddr  in  REG_AW  master decode destination
E_memtoReg  in  ISSUE_W  E-stage load per lane
E_waddr  in  ISSUE_W*REG_AW  E-stage destination per lane
M_memtoReg  in  ISSUE_W  M-stage load per lane
M_waddr  in  ISSUE_W*REG_AW  M-stage destination per lane
E_branch_taken  in  1  branch resolved taken in E
E_div_start  in  1  divide instruction present in E (level)
i_stall  in  1  instruction cache miss
d_stall  in  1  data cache miss
M_except  in  1  exception detected in M
F_ena, D_ena, E_ena, M_ena, W_ena  out  1 each  pipeline register enables
F_flush, D_flush, E_flush, M_flush, W_flush  out  1 each  pipeline register flushes (X_flush clears the register feeding stage X)
D_slave_hold  out  1  slave must not issue this cycle (intra-bundle dependency)
div_ready  out  1  one-cycle pulse: divide result valid, back end released
stall_cnt  out  CNT_W  saturating count of cycles with F_ena==0

Behaviour:
- Register address 0 never matches in any comparison.
- lwstall = OR over decode lanes i with D_valid[i], and over load lanes j in E and M: D_rs[i] or D_rt[i] equals the load's waddr.
- D_slave_hold = D_valid[1] & D_master_regwrite & (slave rs or rt == D_master_waddr). Purely combinational; it does not stall.
- Divider FSM, states RUN and DIV, with counter cnt:
  - RUN, E_div_start=1 → DIV with cnt=1; div_stall is 1 in that cycle.
  - DIV: div_stall=1 while cnt<DIV_CYCLES, and cnt increments each cycle.
  - When cnt==DIV_CYCLES: div_stall=0, div_ready=1, next state RUN. The FSM ignores E_div_start on that cycle.
  - Net effect: div_stall is high for exactly DIV_CYCLES consecutive cycles, then drops together with the div_ready pulse.
- back_stall = d_stall | div_stall.
- Enables:
  - E_ena = M_ena = W_ena = ~back_stall
  - D_ena = ~(back_stall | lwstall)
  - F_ena = ~(back_stall | lwstall | i_stall)
- Exception deferral:
  - M_except & d_stall sets except_pend.
  - except_fire = (M_except | except_pend) & ~d_stall.
  - except_pend clears on except_fire.
  - except_fire forces the FSM to RUN and cnt to 0 next cycle; div_ready stays 0.
- branch_flush = E_branch_taken & ~back_stall & ~except_fire.
- Flushes:
  - F_flush = W_flush = 0
  - D_flush = except_fire | branch_flush | (i_stall & ~lwstall & ~back_stall)
  - E_flush = except_fire | branch_flush | (lwstall & ~back_stall)
  - M_flush = except_fire
- A flush always dominates the enable of the same register.
- stall_cnt increments each cycle F_ena==0 and holds at 2^CNT_W-1.
- Reset (synchronous; a reset mid-divide or mid-pending-exception aborts it):
  - FSM=RUN, cnt=0, except_pend=0, stall_cnt=0, div_ready=0.
  - All enables and flushes follow the combinational equations with internal state cleared.

Test Plan:
- E lane1 load waddr=7, D lane0 rs=7 → F_ena=D_ena=0, E_flush=1 for one cycle; waddr=0 with rs=0 → no stall.
- Slave rt=9, master regwrite waddr=9, both valid → D_slave_hold=1, all enables 1.
- E_div_start pulse, DIV_CYCLES=34 → E_ena=0 for exactly 34 cycles, div_ready=1 on cycle 35, E_ena=1; stall_cnt=34.
- M_except asserted during d_stall for 3 cycles → no flush for 3 cycles; M_flush=D_flush=E_flush=1 the cycle d_stall drops.
- M_except at divide cycle 10 → flushes fire immediately, next cycle E_ena=1, no div_ready pulse.
- i_stall alone → F_ena=0, D_flush=1; E_branch_taken together with d_stall → no branch flush until d_stall clears.
